fpu_result_queue: RTL and testbench

- Registered, buffered stage directly downstream of the combinational Adder/Subtractor.
- Captures {result, error, overflow} with a valid/ready handshake and classifies each result (zero/denormal/normal/inf/qNaN/sNaN).
- Accumulates sticky exception flags and presents results to the writeback consumer in order from a DEPTH-entry FIFO.

---
 rtl/fpu_pkg.sv | 43 ++++
 rtl/fp_classify.sv | 34 +++
 rtl/fpu_result_queue.sv | 151 +++++++++++++++
 tb/tb_fpu_result_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: result classes, round modes, the
// queued entry layout and a saturating counter helper. Used by the result
// queue and by the classifier that the multiplier/divider paths also reuse.
package fpu_pkg;

    // IEEE-754 single-precision classification codes.
    typedef enum logic [2:0] {
        FP_CLASS_ZERO   = 3'd0,
        FP_CLASS_DENORM = 3'd1,
        FP_CLASS_NORMAL = 3'd2,
        FP_CLASS_INF    = 3'd3,
        FP_CLASS_QNAN   = 3'd4,
        FP_CLASS_SNAN   = 3'd5
    } fp_class_t;

    // Round-mode encodings shared with the Adder/Subtractor.
    typedef enum logic [1:0] {
        RM_NEAREST_EVEN = 2'b00,
        RM_TOWARD_ZERO  = 2'b01,
        RM_TOWARD_POS   = 2'b10,
        RM_TOWARD_NEG   = 2'b11
    } round_mode_t;

    // Biased exponent value reserved for infinities and NaNs.
    localparam logic [7:0] FP_EXP_ONES = 8'hFF;

    // One queued result: 32 data + error + overflow + 2 round mode + 3 class.
    localparam int FP_ENTRY_W = 39;

    typedef struct packed {
        logic [31:0] result;
        logic        error;
        logic        overflow;
        round_mode_t round_mode;
        fp_class_t   cls;
    } fp_entry_t;

    // Increment by one when en is set, holding at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
        return (en && (value != 16'hFFFF)) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier: 32-bit value in,
// 3-bit fp_class_t code out. Shared by the add, multiply and divide paths.
module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] value,
    output logic [2:0]  cls
);

    logic [7:0]  exp_field;
    logic [22:0] man_field;

    assign exp_field = value[30:23];
    assign man_field = value[22:0];

    // Decode exponent/mantissa patterns into a class code.
    always_comb begin
        // NOTE: every path of a combinational block must assign the output;
        // giving it a default first guarantees no latch is inferred.
        cls = FP_CLASS_NORMAL;
        if (exp_field == 8'd0) begin
            cls = (man_field == 23'd0) ? FP_CLASS_ZERO : FP_CLASS_DENORM;
        end else if (exp_field == FP_EXP_ONES) begin
            if (man_field == 23'd0) begin
                cls = FP_CLASS_INF;
            end else if (man_field[22]) begin
                cls = FP_CLASS_QNAN;
            end else begin
                cls = FP_CLASS_SNAN;
            end
        end
    end

endmodule

// File: rtl/fpu_result_queue.sv
// Registered result queue behind the Adder/Subtractor. Classifies each
// accepted result, keeps sticky exception flags and presents entries in
// order from a DEPTH-entry FIFO. Full/empty come from the occupancy count,
// so in_ready never depends on out_ready.
// Optional build macro FPU_RESULT_QUEUE_STATS_EN adds saturating push and
// overflow counters (stat_ops, stat_ovf).
module fpu_result_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_error,
    input  logic             in_overflow,
    input  logic [1:0]       in_round_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_error,
    output logic             out_overflow,
    output logic [1:0]       out_round_mode,
    output logic [2:0]       out_class,
    input  logic             flag_clear,
    output logic             sticky_error,
    output logic             sticky_overflow,
    output logic             sticky_invalid,
    output logic [CNT_W-1:0] count
`ifdef FPU_RESULT_QUEUE_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_ovf
`endif
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [FP_ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [2:0]            in_class;
    fp_entry_t             in_entry;
    fp_entry_t             head;
    logic                  push;
    logic                  pop;
    logic                  in_is_nan;

    fp_classify u_classify (
        .value (in_result),
        .cls   (in_class)
    );

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = count_q;
    assign in_is_nan = (in_class == FP_CLASS_QNAN) || (in_class == FP_CLASS_SNAN);

    // Pack the incoming result and its class into one storage word.
    always_comb begin
        in_entry            = '0;
        in_entry.result     = in_result;
        in_entry.error      = in_error;
        in_entry.overflow   = in_overflow;
        in_entry.round_mode = round_mode_t'(in_round_mode);
        in_entry.cls        = fp_class_t'(in_class);
    end

    // Storage array write on every accepted push.
    // NOTE: the array is deliberately left out of reset; nothing reads a slot
    // before it is written, and the head outputs are gated to zero when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky exception flags: a setting push beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_error    <= 1'b0;
            sticky_overflow <= 1'b0;
            sticky_invalid  <= 1'b0;
        end else begin
            sticky_error    <= (sticky_error    & ~flag_clear) | (push & in_error);
            sticky_overflow <= (sticky_overflow & ~flag_clear) | (push & in_overflow);
            sticky_invalid  <= (sticky_invalid  & ~flag_clear) | (push & in_is_nan);
        end
    end

    // Head entry, forced to zero while the queue is empty.
    always_comb begin
        head           = fp_entry_t'(mem[rd_ptr]);
        out_result     = '0;
        out_error      = 1'b0;
        out_overflow   = 1'b0;
        out_round_mode = '0;
        out_class      = '0;
        if (out_valid) begin
            out_result     = head.result;
            out_error      = head.error;
            out_overflow   = head.overflow;
            out_round_mode = head.round_mode;
            out_class      = head.cls;
        end
    end

`ifdef FPU_RESULT_QUEUE_STATS_EN
    // Saturating statistics; a push in the clearing cycle counts after the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else begin
            stat_ops <= sat_inc16(flag_clear ? 16'd0 : stat_ops, push);
            stat_ovf <= sat_inc16(flag_clear ? 16'd0 : stat_ovf, push & in_overflow);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_result_queue.sv
// Directed, table-driven bench for fpu_result_queue (DEPTH = 4). Each table
// row drives the inputs for one clock edge and lists the outputs expected
// just after that edge. A short hand-written sequence then checks that
// in_ready ignores out_ready while full.
module tb_fpu_result_queue;
    import fpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_error;
    logic        in_overflow;
    logic [1:0]  in_round_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_error;
    logic        out_overflow;
    logic [1:0]  out_round_mode;
    logic [2:0]  out_class;
    logic        flag_clear;
    logic        sticky_error;
    logic        sticky_overflow;
    logic        sticky_invalid;
    logic [2:0]  count;
`ifdef FPU_RESULT_QUEUE_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_ovf;
`endif

    fpu_result_queue #(.DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_result       (in_result),
        .in_error        (in_error),
        .in_overflow     (in_overflow),
        .in_round_mode   (in_round_mode),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_error       (out_error),
        .out_overflow    (out_overflow),
        .out_round_mode  (out_round_mode),
        .out_class       (out_class),
        .flag_clear      (flag_clear),
        .sticky_error    (sticky_error),
        .sticky_overflow (sticky_overflow),
        .sticky_invalid  (sticky_invalid),
        .count           (count)
`ifdef FPU_RESULT_QUEUE_STATS_EN
        ,
        .stat_ops        (stat_ops),
        .stat_ovf        (stat_ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n, v;
        logic [31:0] res;
        logic        err, ovf;
        logic [1:0]  rm;
        logic        rdy, clr;
        logic        e_ov, e_ir;
        logic [2:0]  e_cnt;
        logic [31:0] e_res;
        logic [1:0]  e_rm;
        fp_class_t   e_cls;
        logic        e_err, e_ovf;
        logic        e_serr, e_sovf, e_sinv;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_miss    = 0;
    logic prev_ir   = 1'b1;
    logic [15:0] exp_ops = '0;
    logic [15:0] exp_ovf = '0;

    localparam logic [31:0] VA = 32'h3F800000;
    localparam logic [31:0] VB = 32'h40000000;
    localparam logic [31:0] VC = 32'h40400000;
    localparam logic [31:0] VD = 32'h40800000;
    localparam logic [31:0] VE = 32'h40A00000;
    localparam logic [31:0] F1 = 32'h41000000;
    localparam logic [31:0] F2 = 32'h41100000;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic add(
        input logic r, input logic v, input logic [31:0] res, input logic err, input logic ovf,
        input logic [1:0] rm, input logic rdy, input logic clr,
        input logic e_ov, input logic e_ir, input logic [2:0] e_cnt, input logic [31:0] e_res,
        input logic [1:0] e_rm, input fp_class_t e_cls, input logic e_err, input logic e_ovf,
        input logic e_serr, input logic e_sovf, input logic e_sinv);
        vec_t x;
        x.rst_n = r;  x.v = v;  x.res = res;  x.err = err;  x.ovf = ovf;
        x.rm = rm;  x.rdy = rdy;  x.clr = clr;
        x.e_ov = e_ov;  x.e_ir = e_ir;  x.e_cnt = e_cnt;  x.e_res = e_res;
        x.e_rm = e_rm;  x.e_cls = e_cls;  x.e_err = e_err;  x.e_ovf = e_ovf;
        x.e_serr = e_serr;  x.e_sovf = e_sovf;  x.e_sinv = e_sinv;
        vecs.push_back(x);
    endtask

    function automatic logic [31:0] g_val(input int k);
        return 32'h41200000 + (k << 12);
    endfunction

    task automatic apply(input vec_t x, input int idx);
        logic pushed;
        rst_n         = x.rst_n;
        in_valid      = x.v;
        in_result     = x.res;
        in_error      = x.err;
        in_overflow   = x.ovf;
        in_round_mode = x.rm;
        out_ready     = x.rdy;
        flag_clear    = x.clr;
        pushed = x.rst_n & x.v & prev_ir;
        if (!x.rst_n) begin
            exp_ops = '0;
            exp_ovf = '0;
        end else begin
            if (x.clr) begin
                exp_ops = '0;
                exp_ovf = '0;
            end
            if (pushed && exp_ops != 16'hFFFF) exp_ops = exp_ops + 16'd1;
            if (pushed && x.ovf && exp_ovf != 16'hFFFF) exp_ovf = exp_ovf + 16'd1;
        end
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_valid", idx),       32'(out_valid),       32'(x.e_ov));
        check($sformatf("v%0d in_ready", idx),        32'(in_ready),        32'(x.e_ir));
        check($sformatf("v%0d count", idx),           32'(count),           32'(x.e_cnt));
        check($sformatf("v%0d out_result", idx),      out_result,           x.e_res);
        check($sformatf("v%0d out_round_mode", idx),  32'(out_round_mode),  32'(x.e_rm));
        check($sformatf("v%0d out_class", idx),       32'(out_class),       32'(x.e_cls));
        check($sformatf("v%0d out_error", idx),       32'(out_error),       32'(x.e_err));
        check($sformatf("v%0d out_overflow", idx),    32'(out_overflow),    32'(x.e_ovf));
        check($sformatf("v%0d sticky_error", idx),    32'(sticky_error),    32'(x.e_serr));
        check($sformatf("v%0d sticky_overflow", idx), 32'(sticky_overflow), 32'(x.e_sovf));
        check($sformatf("v%0d sticky_invalid", idx),  32'(sticky_invalid),  32'(x.e_sinv));
`ifdef FPU_RESULT_QUEUE_STATS_EN
        check($sformatf("v%0d stat_ops", idx),        32'(stat_ops),        32'(exp_ops));
        check($sformatf("v%0d stat_ovf", idx),        32'(stat_ovf),        32'(exp_ovf));
`endif
        prev_ir = x.e_ir;
    endtask

    initial begin
        rst_n = 1'b0;  in_valid = 1'b0;  in_result = '0;  in_error = 1'b0;
        in_overflow = 1'b0;  in_round_mode = '0;  out_ready = 1'b0;  flag_clear = 1'b0;

        // Reset with junk on the inputs.
        add(0,1,32'h12345678,1,1,2'd3,1,0, 0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 0,0,0);
        add(0,1,32'h12345678,1,1,2'd3,1,0, 0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 0,0,0);
        // Single push, one-cycle latency, then pop.
        add(1,1,32'h416F0000,0,0,2'd0,0,0, 1,1,3'd1,32'h416F0000,2'd0,FP_CLASS_NORMAL,0,0, 0,0,0);
        add(1,0,32'h0,0,0,2'd0,1,0,        0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 0,0,0);
        // Fill to four, stall a fifth push, then drain in order.
        add(1,1,VA,0,0,2'd1,0,0, 1,1,3'd1,VA,2'd1,FP_CLASS_NORMAL,0,0, 0,0,0);
        add(1,1,VB,0,0,2'd2,0,0, 1,1,3'd2,VA,2'd1,FP_CLASS_NORMAL,0,0, 0,0,0);
        add(1,1,VC,1,0,2'd3,0,0, 1,1,3'd3,VA,2'd1,FP_CLASS_NORMAL,0,0, 1,0,0);
        add(1,1,VD,0,0,2'd0,0,0, 1,0,3'd4,VA,2'd1,FP_CLASS_NORMAL,0,0, 1,0,0);
        add(1,1,VE,0,0,2'd1,0,0, 1,0,3'd4,VA,2'd1,FP_CLASS_NORMAL,0,0, 1,0,0);
        add(1,1,VE,0,0,2'd1,1,0, 1,1,3'd3,VB,2'd2,FP_CLASS_NORMAL,0,0, 1,0,0);
        add(1,1,VE,0,0,2'd1,1,0, 1,1,3'd3,VC,2'd3,FP_CLASS_NORMAL,1,0, 1,0,0);
        add(1,0,32'h0,0,0,2'd0,1,0, 1,1,3'd2,VD,2'd0,FP_CLASS_NORMAL,0,0, 1,0,0);
        add(1,0,32'h0,0,0,2'd0,1,0, 1,1,3'd1,VE,2'd1,FP_CLASS_NORMAL,0,0, 1,0,0);
        add(1,0,32'h0,0,0,2'd0,1,0, 0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 1,0,0);
        // Sustained push+pop at count 2; pointers wrap several times.
        add(1,1,F1,0,0,2'd2,0,0, 1,1,3'd1,F1,2'd2,FP_CLASS_NORMAL,0,0, 1,0,0);
        add(1,1,F2,0,0,2'd2,0,0, 1,1,3'd2,F1,2'd2,FP_CLASS_NORMAL,0,0, 1,0,0);
        for (int k = 1; k <= 10; k++) begin
            add(1,1,g_val(k),0,0,2'd2,1,0, 1,1,3'd2,(k == 1) ? F2 : g_val(k-1),2'd2,FP_CLASS_NORMAL,0,0, 1,0,0);
        end
        add(1,0,32'h0,0,0,2'd0,1,0, 1,1,3'd1,g_val(10),2'd2,FP_CLASS_NORMAL,0,0, 1,0,0);
        add(1,0,32'h0,0,0,2'd0,1,0, 0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 1,0,0);
        add(1,0,32'h0,0,0,2'd0,0,1, 0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 0,0,0);
        // Classification sweep with push+pop each cycle.
        add(1,1,32'h00000000,0,0,2'd0,1,0, 1,1,3'd1,32'h00000000,2'd0,FP_CLASS_ZERO,0,0, 0,0,0);
        add(1,1,32'h00000001,0,0,2'd0,1,0, 1,1,3'd1,32'h00000001,2'd0,FP_CLASS_DENORM,0,0, 0,0,0);
        add(1,1,32'h7F800000,0,0,2'd0,1,0, 1,1,3'd1,32'h7F800000,2'd0,FP_CLASS_INF,0,0, 0,0,0);
        add(1,1,32'h7FC00000,0,0,2'd0,1,0, 1,1,3'd1,32'h7FC00000,2'd0,FP_CLASS_QNAN,0,0, 0,0,1);
        add(1,1,32'h7F800001,0,0,2'd0,1,0, 1,1,3'd1,32'h7F800001,2'd0,FP_CLASS_SNAN,0,0, 0,0,1);
        add(1,0,32'h0,0,0,2'd0,1,0,        0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 0,0,1);
        // Sticky flags: clear alone, set, clear, clear+set, clear+non-setting push.
        add(1,0,32'h0,0,0,2'd0,0,1, 0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 0,0,0);
        add(1,1,VA,0,1,2'd0,1,0,    1,1,3'd1,VA,2'd0,FP_CLASS_NORMAL,0,1, 0,1,0);
        add(1,0,32'h0,0,0,2'd0,1,1, 0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 0,0,0);
        add(1,1,VB,0,1,2'd0,1,1,    1,1,3'd1,VB,2'd0,FP_CLASS_NORMAL,0,1, 0,1,0);
        add(1,1,VC,0,0,2'd0,1,1,    1,1,3'd1,VC,2'd0,FP_CLASS_NORMAL,0,0, 0,0,0);
        add(1,0,32'h0,0,0,2'd0,1,0, 0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 0,0,0);
        // Reset mid-stream with three entries queued and flags set.
        add(1,1,VA,1,1,2'd0,0,0,          1,1,3'd1,VA,2'd0,FP_CLASS_NORMAL,1,1, 1,1,0);
        add(1,1,32'h7FC00000,0,0,2'd0,0,0, 1,1,3'd2,VA,2'd0,FP_CLASS_NORMAL,1,1, 1,1,1);
        add(1,1,VB,0,0,2'd0,0,0,          1,1,3'd3,VA,2'd0,FP_CLASS_NORMAL,1,1, 1,1,1);
        add(0,1,VC,1,1,2'd0,1,0,          0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 0,0,0);
        add(1,1,VD,0,0,2'd1,0,0,          1,1,3'd1,VD,2'd1,FP_CLASS_NORMAL,0,0, 0,0,0);
        add(1,0,32'h0,0,0,2'd0,1,0,       0,1,3'd0,32'h0,2'd0,FP_CLASS_ZERO,0,0, 0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Full queue: in_ready stays low while out_ready is high, rises after the pop.
        rst_n = 1'b1;  flag_clear = 1'b0;  out_ready = 1'b0;  in_error = 1'b0;
        in_overflow = 1'b0;  in_round_mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_result = 32'h42000000 + 32'(i);
            @(posedge clk);
            #1;
        end
        in_result = 32'h42000010;
        out_ready = 1'b1;
        #1;
        check("full in_ready with out_ready high", 32'(in_ready), 32'd0);
        check("full head result", out_result, 32'h42000000);
        @(posedge clk);
        #1;
        check("in_ready after pop from full", 32'(in_ready), 32'd1);
        check("count after pop from full", 32'(count), 32'd3);
        check("head after pop from full", out_result, 32'h42000001);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
